// File: rtl/spi_pkg.sv
// spi_pkg: shared definitions for the SPI responder.
//   - SPI mode constants (mode 0, MSB first)
//   - FSM state encoding
//   - default word width (tied to the CPU word) and default fill word
package spi_pkg;

  // Only mode 0 is implemented: sclk idles low, data sampled on the rising
  // edge and changed on the falling edge, most significant bit first.
  localparam logic CPOL      = 1'b0;
  localparam logic CPHA      = 1'b0;
  localparam logic MSB_FIRST = 1'b1;

  localparam int unsigned W_CPU      = 32;
  localparam int unsigned W_DATA_DEF = W_CPU;

  // Shifted out on MISO when the CPU has not queued a word in time.
  localparam logic [W_CPU-1:0] FILL_WORD_DEF = '0;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } spi_state_e;

endpackage

// File: rtl/spi_sync.sv
// spi_sync: 2-FF synchronizer for one asynchronous input, with edge detect.
//   clk, rst : system clock, async active-low reset
//   d_in     : asynchronous input
//   q        : synchronized level
//   rise     : one-cycle pulse when q goes 0 -> 1
//   fall     : one-cycle pulse when q goes 1 -> 0
// RST_VAL is the idle level of the pin, so reset never produces a false edge.
module spi_sync #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d_in,
  output logic q,
  output logic rise,
  output logic fall
);

  logic ff1_q, ff1_d;
  logic ff2_q, ff2_d;
  logic prev_q, prev_d;

  always_comb begin
    ff1_d  = d_in;
    ff2_d  = ff1_q;
    prev_d = ff2_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ff1_q  <= RST_VAL;
      ff2_q  <= RST_VAL;
      prev_q <= RST_VAL;
    end else begin
      ff1_q  <= ff1_d;
      ff2_q  <= ff2_d;
      prev_q <= prev_d;
    end
  end

  assign q    = ff2_q;
  assign rise = ff2_q & ~prev_q;
  assign fall = ~ff2_q & prev_q;

endmodule

// File: rtl/spi_peripheral.sv
// spi_peripheral: SPI responder (mode 0, MSB first, fixed word width).
// All SPI pins are oversampled in the clk domain; nothing runs on sclk.
//   clk, rst          : system clock, async active-low reset
//   sclk, cs_n, mosi  : SPI pins from the controller (asynchronous)
//   miso, miso_oe     : SPI data out and its enable (high while selected)
//   tx_data/valid/ready : CPU-side TX word, valid/ready handshake into a
//                       single-word buffer
//   rx_data, rx_valid : last complete received word, one-cycle update pulse
//   tx_underrun       : pulse when FILL_WORD is sent for lack of TX data
//   frame_abort       : pulse when cs_n rises with a partial word received
// W_CNT must satisfy 2**W_CNT > W_DATA. The sclk period must be at least
// 4 clk periods so every edge is seen after synchronization.
module spi_peripheral
  import spi_pkg::*;
#(
  parameter int unsigned       W_DATA    = W_DATA_DEF,
  parameter int unsigned       W_CNT     = 6,
  parameter logic [W_DATA-1:0] FILL_WORD = W_DATA'(FILL_WORD_DEF)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sclk,
  input  logic              cs_n,
  input  logic              mosi,
  output logic              miso,
  output logic              miso_oe,
  input  logic [W_DATA-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic [W_DATA-1:0] rx_data,
  output logic              rx_valid,
  output logic              tx_underrun,
  output logic              frame_abort
);

  localparam logic [W_CNT-1:0] LAST_BIT = W_CNT'(W_DATA - 1);

  // ---------------------------------------------------------------------
  // Pin synchronization
  // ---------------------------------------------------------------------
  logic sclk_s, sclk_rise, sclk_fall;
  logic cs_n_s, cs_rise, cs_fall;
  logic mosi_s, mosi_rise_unused, mosi_fall_unused;

  spi_sync #(.RST_VAL(1'b0)) u_sync_sclk (
    .clk (clk), .rst (rst), .d_in (sclk),
    .q   (sclk_s), .rise (sclk_rise), .fall (sclk_fall)
  );

  spi_sync #(.RST_VAL(1'b1)) u_sync_cs (
    .clk (clk), .rst (rst), .d_in (cs_n),
    .q   (cs_n_s), .rise (cs_rise), .fall (cs_fall)
  );

  spi_sync #(.RST_VAL(1'b0)) u_sync_mosi (
    .clk (clk), .rst (rst), .d_in (mosi),
    .q   (mosi_s), .rise (mosi_rise_unused), .fall (mosi_fall_unused)
  );

  // ---------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------
  spi_state_e        state_q, state_d;
  logic [W_CNT-1:0]  cnt_q, cnt_d;
  logic [W_DATA-1:0] tx_shift_q, tx_shift_d;
  // The final bit of a word goes straight into rx_data, so the shifter
  // only needs to hold W_DATA-1 bits.
  logic [W_DATA-2:0] rx_shift_q, rx_shift_d;
  logic              word_done_q, word_done_d;
  logic [W_DATA-1:0] tx_buf_q, tx_buf_d;
  logic              tx_full_q, tx_full_d;
  logic              miso_q, miso_d;
  logic              miso_oe_q, miso_oe_d;
  logic [W_DATA-1:0] rx_data_q, rx_data_d;
  logic              rx_valid_q, rx_valid_d;
  logic              tx_underrun_q, tx_underrun_d;
  logic              frame_abort_q, frame_abort_d;

  logic              reload;
  logic [W_DATA-1:0] reload_word;

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    tx_shift_d    = tx_shift_q;
    rx_shift_d    = rx_shift_q;
    word_done_d   = word_done_q;
    tx_buf_d      = tx_buf_q;
    tx_full_d     = tx_full_q;
    miso_d        = miso_q;
    miso_oe_d     = miso_oe_q;
    rx_data_d     = rx_data_q;
    rx_valid_d    = 1'b0;
    tx_underrun_d = 1'b0;
    frame_abort_d = 1'b0;
    reload        = 1'b0;
    reload_word   = tx_full_q ? tx_buf_q : FILL_WORD;

    case (state_q)
      ST_IDLE: begin
        miso_oe_d = 1'b0;
        miso_d    = 1'b0;
        if (cs_fall) begin
          reload      = 1'b1;
          miso_oe_d   = 1'b1;
          cnt_d       = '0;
          word_done_d = 1'b0;
          state_d     = ST_SHIFT;
        end
      end

      ST_SHIFT: begin
        // cs_n rising takes priority over any sclk edge seen in the same cycle.
        if (cs_rise) begin
          frame_abort_d = (cnt_q != '0);
          miso_oe_d     = 1'b0;
          miso_d        = 1'b0;
          word_done_d   = 1'b0;
          state_d       = ST_IDLE;
        end else if (sclk_rise) begin
          rx_shift_d = {rx_shift_q[W_DATA-3:0], mosi_s};
          if (cnt_q == LAST_BIT) begin
            rx_data_d   = {rx_shift_q, mosi_s};
            rx_valid_d  = 1'b1;
            cnt_d       = '0;
            word_done_d = 1'b1;
          end else begin
            cnt_d = cnt_q + W_CNT'(1);
          end
        end else if (sclk_fall) begin
          // The falling edge after a word's last sample starts the next word,
          // giving gapless back-to-back words within a frame.
          if (word_done_q) begin
            reload      = 1'b1;
            word_done_d = 1'b0;
          end else begin
            tx_shift_d = tx_shift_q << 1;
            miso_d     = tx_shift_q[W_DATA-2];
          end
        end
      end

      default: state_d = ST_IDLE;
    endcase

    if (reload) begin
      tx_shift_d    = reload_word;
      miso_d        = reload_word[W_DATA-1];
      tx_underrun_d = ~tx_full_q;
    end

    // A reload drains the buffer; tx_ready only rises the cycle after, so a
    // word offered in the reload cycle waits one cycle. With an empty buffer
    // tx_ready is already high and a same-cycle offer is accepted.
    if (reload && tx_full_q) begin
      tx_full_d = 1'b0;
    end else if (tx_valid && !tx_full_q) begin
      tx_buf_d  = tx_data;
      tx_full_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= ST_IDLE;
      cnt_q         <= '0;
      tx_shift_q    <= '0;
      rx_shift_q    <= '0;
      word_done_q   <= 1'b0;
      tx_buf_q      <= '0;
      tx_full_q     <= 1'b0;
      miso_q        <= 1'b0;
      miso_oe_q     <= 1'b0;
      rx_data_q     <= '0;
      rx_valid_q    <= 1'b0;
      tx_underrun_q <= 1'b0;
      frame_abort_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      tx_shift_q    <= tx_shift_d;
      rx_shift_q    <= rx_shift_d;
      word_done_q   <= word_done_d;
      tx_buf_q      <= tx_buf_d;
      tx_full_q     <= tx_full_d;
      miso_q        <= miso_d;
      miso_oe_q     <= miso_oe_d;
      rx_data_q     <= rx_data_d;
      rx_valid_q    <= rx_valid_d;
      tx_underrun_q <= tx_underrun_d;
      frame_abort_q <= frame_abort_d;
    end
  end

  assign miso        = miso_q;
  assign miso_oe     = miso_oe_q;
  assign tx_ready    = ~tx_full_q;
  assign rx_data     = rx_data_q;
  assign rx_valid    = rx_valid_q;
  assign tx_underrun = tx_underrun_q;
  assign frame_abort = frame_abort_q;

endmodule

// File: tb/tb_spi_peripheral.sv
// Bench for spi_peripheral with W_DATA=8, FILL_WORD=0xFF, clk:sclk = 8:1.
// The SPI controller model ends each frame by raising cs_n together with the
// final sclk fall, so no trailing reload happens after the last word.
module tb_spi_peripheral;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       sclk = 1'b0;
  logic       cs_n = 1'b1;
  logic       mosi = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       miso, miso_oe, tx_ready, rx_valid, tx_underrun, frame_abort;
  logic [7:0] rx_data;

  always #5 clk = ~clk;

  spi_peripheral #(.W_DATA(8), .W_CNT(4), .FILL_WORD(8'hFF)) dut (
    .clk(clk), .rst(rst), .sclk(sclk), .cs_n(cs_n), .mosi(mosi),
    .miso(miso), .miso_oe(miso_oe),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid),
    .tx_underrun(tx_underrun), .frame_abort(frame_abort)
  );

  int tests = 0;
  int fails = 0;

  // Monitor: running totals only, sampled on the falling clk edge.
  int         rxv_cnt = 0, und_cnt = 0, abt_cnt = 0, acc_cnt = 0;
  logic [7:0] rx_log[$];
  always @(negedge clk) begin
    if (rst) begin
      if (rx_valid) begin rxv_cnt++; rx_log.push_back(rx_data); end
      if (tx_underrun) und_cnt++;
      if (frame_abort) abt_cnt++;
      if (tx_valid && tx_ready) acc_cnt++;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tx_push(input logic [7:0] d);
    int n = 0;
    @(negedge clk);
    while (!tx_ready && n < 2000) begin @(negedge clk); n++; end
    tests++;
    if (!tx_ready) begin
      fails++;
      $display("FAIL tx_push_wait: tx_ready stayed 0 for %0d cycles, need 1", n);
    end
    tx_data = d; tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
  endtask

  // SPI controller: mode 0, MSB first; miso sampled just before each rise.
  logic [7:0] mosi_w[4];
  logic [7:0] miso_w[4];
  task automatic spi_xfer(input int nbits);
    @(negedge clk);
    cs_n = 1'b0;
    mosi = mosi_w[0][7];
    for (int i = 0; i < nbits; i++) begin
      #40;
      miso_w[i/8][7-(i%8)] = miso;
      sclk = 1'b1;
      #40;
      sclk = 1'b0;
      if (i == nbits - 1) cs_n = 1'b1;
      else mosi = mosi_w[(i+1)/8][7-((i+1)%8)];
    end
    #80;
  endtask

  function automatic logic [7:0] log_at(input int idx);
    if (idx < rx_log.size()) return rx_log[idx];
    return 8'hxx;
  endfunction

  typedef struct {
    logic       load;
    logic [7:0] txw;
    logic [7:0] mw;
    int         nbits;
    logic [7:0] exp_miso;
    logic [7:0] exp_rx;
    int         exp_rxv;
    int         exp_und;
    int         exp_abt;
  } vec_t;

  vec_t vecs[5];

  initial begin
    int b_rx, b_u, b_a, b_acc, qi, nw;
    logic [7:0] mask, txw, em;
    logic pre;

    vecs[0] = '{1'b1, 8'hA5, 8'h3C, 8, 8'hA5, 8'h3C, 1, 0, 0};
    vecs[1] = '{1'b0, 8'h00, 8'h00, 8, 8'hFF, 8'h00, 1, 1, 0};
    vecs[2] = '{1'b1, 8'h5A, 8'hC3, 5, 8'h5A, 8'h00, 0, 0, 1};
    vecs[3] = '{1'b0, 8'h00, 8'h96, 8, 8'hFF, 8'h96, 1, 1, 0};
    vecs[4] = '{1'b1, 8'h01, 8'h80, 8, 8'h01, 8'h80, 1, 0, 0};

    // Reset state
    #23;
    chk("rst_miso", miso, 0);
    chk("rst_miso_oe", miso_oe, 0);
    chk("rst_tx_ready", tx_ready, 1);
    chk("rst_rx_data", rx_data, 0);
    chk("rst_rx_valid", rx_valid, 0);
    chk("rst_underrun", tx_underrun, 0);
    chk("rst_abort", frame_abort, 0);
    @(negedge clk); rst = 1'b1;
    repeat (4) @(negedge clk);

    // Table-driven single frames
    for (int i = 0; i < 5; i++) begin
      b_rx = rxv_cnt; b_u = und_cnt; b_a = abt_cnt;
      if (vecs[i].load) tx_push(vecs[i].txw);
      mosi_w[0] = vecs[i].mw;
      spi_xfer(vecs[i].nbits);
      mask = 8'hFF;
      mask = mask << (8 - vecs[i].nbits);
      chk($sformatf("v%0d_miso", i), miso_w[0] & mask, vecs[i].exp_miso & mask);
      chk($sformatf("v%0d_rx_data", i), rx_data, vecs[i].exp_rx);
      chk($sformatf("v%0d_rx_valid_cnt", i), rxv_cnt - b_rx, vecs[i].exp_rxv);
      chk($sformatf("v%0d_underrun_cnt", i), und_cnt - b_u, vecs[i].exp_und);
      chk($sformatf("v%0d_abort_cnt", i), abt_cnt - b_a, vecs[i].exp_abt);
      chk($sformatf("v%0d_tx_ready", i), tx_ready, 1);
      chk($sformatf("v%0d_miso_oe", i), miso_oe, 0);
    end

    // Two-word frame, second TX word loaded during word 1
    b_rx = rxv_cnt; b_u = und_cnt; qi = rx_log.size();
    tx_push(8'h11);
    mosi_w[0] = 8'h81; mosi_w[1] = 8'h7E;
    fork
      spi_xfer(16);
      begin #200; tx_push(8'h22); end
    join
    chk("two_miso0", miso_w[0], 8'h11);
    chk("two_miso1", miso_w[1], 8'h22);
    chk("two_rxv_cnt", rxv_cnt - b_rx, 2);
    chk("two_rx0", log_at(qi), 8'h81);
    chk("two_rx1", log_at(qi + 1), 8'h7E);
    chk("two_underrun", und_cnt - b_u, 0);

    // tx_valid held against a full buffer
    b_u = und_cnt;
    tx_push(8'h33);
    @(negedge clk);
    tx_data = 8'h44; tx_valid = 1'b1;
    b_acc = acc_cnt;
    repeat (5) @(negedge clk);
    chk("bp_ready_low", tx_ready, 0);
    chk("bp_no_accept", acc_cnt - b_acc, 0);
    mosi_w[0] = 8'h5A;
    spi_xfer(8);
    tx_valid = 1'b0;
    chk("bp_miso_old", miso_w[0], 8'h33);
    chk("bp_accept_once", acc_cnt - b_acc, 1);
    chk("bp_ready_full", tx_ready, 0);
    mosi_w[0] = 8'hA5;
    spi_xfer(8);
    chk("bp_miso_new", miso_w[0], 8'h44);
    chk("bp_ready_end", tx_ready, 1);
    chk("bp_underrun", und_cnt - b_u, 0);

    // Asynchronous reset mid-word
    b_rx = rxv_cnt; b_a = abt_cnt;
    tx_push(8'h5A);
    mosi_w[0] = 8'hC3;
    fork
      spi_xfer(8);
      begin
        #290;
        chk("mid_miso_oe_on", miso_oe, 1);
        #10;
        rst = 1'b0;
        #1;
        chk("mid_rst_miso", miso, 0);
        chk("mid_rst_miso_oe", miso_oe, 0);
        chk("mid_rst_tx_ready", tx_ready, 1);
        chk("mid_rst_rx_data", rx_data, 0);
        chk("mid_rst_rx_valid", rx_valid, 0);
        chk("mid_rst_underrun", tx_underrun, 0);
        chk("mid_rst_abort", frame_abort, 0);
      end
    join
    @(negedge clk); rst = 1'b1;
    repeat (4) @(negedge clk);
    chk("mid_rst_no_rx", rxv_cnt - b_rx, 0);
    chk("mid_rst_no_abort", abt_cnt - b_a, 0);

    // Randomized frames against a word-level model: each word of a frame
    // takes the queued TX word if there is one, otherwise FILL_WORD.
    for (int it = 0; it < 16; it++) begin
      pre = 1'($urandom_range(0, 1));
      nw  = int'($urandom_range(1, 2));
      txw = 8'($urandom);
      for (int k = 0; k < 2; k++) mosi_w[k] = 8'($urandom);
      b_rx = rxv_cnt; b_u = und_cnt; b_a = abt_cnt; qi = rx_log.size();
      if (pre) tx_push(txw);
      spi_xfer(nw * 8);
      chk($sformatf("r%0d_rxv_cnt", it), rxv_cnt - b_rx, nw);
      for (int k = 0; k < nw; k++) begin
        em = (k == 0 && pre) ? txw : 8'hFF;
        chk($sformatf("r%0d_miso%0d", it, k), miso_w[k], em);
        chk($sformatf("r%0d_rx%0d", it, k), log_at(qi + k), mosi_w[k]);
      end
      chk($sformatf("r%0d_underrun", it), und_cnt - b_u, (pre ? 0 : 1) + (nw - 1));
      chk($sformatf("r%0d_abort", it), abt_cnt - b_a, 0);
      chk($sformatf("r%0d_tx_ready", it), tx_ready, 1);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/spi_peripheral.md
Name: spi_peripheral

Overview:
- Responder (slave) end of the team's SPI link: receives serial MOSI words from an external SPI controller and returns MISO words loaded by the CPU side.
- SPI mode 0 only (CPOL=0, CPHA=0), MSB first, fixed word width.
- All SPI pins are oversampled in the system clk domain; no logic is clocked by sclk.
- Sits between the SPI pins and the CPU load/store datapath.

Parameters:
- W_DATA, 32, bits per SPI word (matches W_CPU).
- W_CNT, 6, bit-counter width; must satisfy 2^W_CNT > W_DATA.
- FILL_WORD, 0, word shifted out on MISO when no TX data is queued.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, asynchronous, active-low.
- sclk  in  1  SPI clock from the controller (asynchronous to clk).
- cs_n  in  1  chip select, active-low (asynchronous).
- mosi  in  1  serial data from the controller.
- miso  out  1  serial data to the controller.
- miso_oe  out  1  MISO output enable; high only while selected.
- tx_data  in  W_DATA  next word to return.
- tx_valid  in  1  tx_data is valid.
- tx_ready  out  1  TX buffer is empty; a transfer occurs when tx_valid and tx_ready are both high.
- rx_data  out  W_DATA  last fully received word.
- rx_valid  out  1  one-cycle pulse when rx_data is updated.
- tx_underrun  out  1  one-cycle pulse when FILL_WORD is substituted for missing TX data.
- frame_abort  out  1  one-cycle pulse when cs_n rises mid-word.

Behaviour:
- Reset (rst low, async) values: miso=0, miso_oe=0, tx_ready=1, rx_data=0, rx_valid=0, tx_underrun=0, frame_abort=0. Synchronizer stages reset to sclk=0, cs_n=1, mosi=0. Bit counter=0, state=IDLE.
- Input synchronization: sclk, cs_n and mosi each pass through a 2-FF synchronizer. Edges are detected from the synchronized value versus its previous registered value.
- Timing constraint: the sclk period must be at least 4 clk periods, and mosi must be stable around each sclk rising edge for at least 2 clk periods.
- TX buffer: a single word register.
  - tx_valid & tx_ready loads the buffer; tx_ready falls on the next cycle.
  - tx_ready returns high in the cycle after the buffer is copied into the TX shift register.
- FSM state IDLE:
  - Entered from reset and whenever cs_n_sync=1. miso_oe=0.
  - On the cs_n_sync falling edge: load the TX shift register from the buffer if it is full, otherwise load FILL_WORD and pulse tx_underrun.
  - Drive miso with the shift register MSB, set miso_oe=1, clear the bit counter, go to SHIFT.
- FSM state SHIFT:
  - sclk rising edge: rx_shift <= {rx_shift[W_DATA-2:0], mosi_sync}; bit counter increments.
    - If the counter reaches W_DATA-1 before incrementing: rx_data <= the completed word, rx_valid pulses in that same cycle, counter resets to 0, and word_done is set.
  - sclk falling edge:
    - If word_done: reload the TX shift register per the IDLE rule (including underrun), present the new MSB on miso, clear word_done.
    - Otherwise: shift the TX register left and present the next bit on miso.
  - Back-to-back words within one frame are supported with no gap.
- cs_n_sync rises while in SHIFT:
  - If the counter is nonzero: partial word is discarded, rx_data is unchanged, frame_abort pulses.
  - If the counter is 0: clean end of frame, no pulse.
  - In both cases go to IDLE, miso_oe=0; the TX buffer content is retained.
- Simultaneous events:
  - Buffer reload and a new tx_valid in the same cycle: the reload takes the old buffer word, tx_ready stays low, and the new word is not accepted until the next cycle.
  - An sclk edge and a cs_n rise detected in the same cycle: the cs_n rise wins and the edge is ignored.
- Reset mid-frame: all state is cleared immediately and asynchronously; the partial word is lost with no pulses.
- rx_valid has no backpressure: the consumer must take rx_data within W_DATA sclk periods.

Decomposition:
- Shared package spi_pkg:
  - SPI mode constants (CPOL, CPHA, MSB_FIRST).
  - FSM state encoding (IDLE, SHIFT).
  - Default W_DATA (tied to W_CPU).
  - Default FILL_WORD.
- Sub-module spi_sync: parameterizable 2-FF synchronizer with reset value and edge-detect outputs (rise, fall). Instantiated three times.

Test Plan (bench uses W_DATA=8, clk:sclk = 8:1):
- Load tx_data=0xA5, then a frame with mosi word 0x3C -> miso bits 1,0,1,0,0,1,0,1; rx_data=0x3C; rx_valid high exactly one clk; tx_ready back to 1.
- Frame with no TX loaded, FILL_WORD=0xFF, mosi=0x00 -> tx_underrun pulses once at cs_n fall; miso all 1s; rx_data=0x00.
- Two-word frame: 0x11 queued, then 0x22 loaded during word 1; mosi 0x81,0x7E -> miso 0x11 then 0x22; two rx_valid pulses with 0x81 then 0x7E.
- cs_n raised after 5 bits -> frame_abort pulses once, no rx_valid, rx_data keeps its prior value; the next full frame receives correctly.
- rst asserted low mid-word -> all outputs reach reset values without a clk edge; miso_oe=0; tx_ready=1.
- tx_valid held with a full buffer -> tx_ready=0, no overwrite; the word is accepted in the cycle after the buffer is drained.
